// File: rtl/full_adder4.sv
// Registered 4-bit ripple-carry adder: {cout, out} = in1 + in2 + cin.
// Latency: 1 clock. A new addition is accepted every cycle.
// Backpressure: none. The output register loads on every edge.
module full_adder4 (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       cin,
    output logic [3:0] out,
    output logic       cout,
    input  logic       clk,
    input  logic       rst_n
);

    logic [3:0] sum_d;
    logic [4:0] carry;
    logic [3:0] sum_q;
    logic       cout_q;

    // Four full-adder cells chained through carry[i] -> carry[i+1].
    always_comb begin
        sum_d    = 4'b0000;
        carry    = 5'b00000;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum_d[i]   = in1[i] ^ in2[i] ^ carry[i];
            carry[i+1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= 4'b0000;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= carry[4];
        end
    end

    assign out  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_full_adder4.sv
// Self-checking bench for full_adder4 against a plain arithmetic reference.
module tb_full_adder4;

    logic [3:0] in1;
    logic [3:0] in2;
    logic       cin;
    logic [3:0] out;
    logic       cout;
    logic       clk;
    logic       rst_n;

    int errors;
    int checks;

    full_adder4 dut (
        .in1   (in1),
        .in2   (in2),
        .cin   (cin),
        .out   (out),
        .cout  (cout),
        .clk   (clk),
        .rst_n (rst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got cout=%0b out=%0d, expected cout=%0b out=%0d",
                     tag, got[4], got[3:0], exp[4], exp[3:0]);
        end
    endtask

    function automatic logic [4:0] ref_sum(input logic [3:0] a, input logic [3:0] b, input logic c);
        int total;
        total = int'(a) + int'(b) + int'(c);
        return total[4:0];
    endfunction

    // Drive one vector between edges, then check the result just after the next edge.
    task automatic apply_vec(input string tag, input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] exp;
        @(negedge clk);
        in1 = a;
        in2 = b;
        cin = c;
        exp = ref_sum(a, b, c);
        @(posedge clk);
        #1;
        check_eq(tag, {cout, out}, exp);
    endtask

    logic [3:0] tab_a [11] = '{4'd0, 4'd2, 4'd2, 4'd11, 4'd5, 4'd7, 4'd9, 4'd9, 4'd11, 4'd15, 4'd15};
    logic [3:0] tab_b [11] = '{4'd0, 4'd0, 4'd2, 4'd2,  4'd3, 4'd7, 4'd7, 4'd9, 4'd11, 4'd15, 4'd0};
    logic       tab_c [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] tab_e [11] = '{5'd0, 5'd3, 5'd4, 5'd14, 5'd8, 5'd15, 5'd16, 5'd19, 5'd22, 5'd31, 5'd16};

    initial begin
        logic [4:0] held;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        errors = 0;
        checks = 0;

        // Reset with all-ones inputs: outputs cleared, held through edges.
        rst_n = 1'b0;
        in1   = 4'hF;
        in2   = 4'hF;
        cin   = 1'b1;
        #1;
        check_eq("reset_initial", {cout, out}, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held", {cout, out}, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_release_no_edge", {cout, out}, 5'd0);
        @(posedge clk);
        #1;
        check_eq("first_load_after_reset", {cout, out}, 5'h1F);

        // Async assertion mid-cycle clears immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_clear", {cout, out}, 5'd0);
        #1;
        rst_n = 1'b1;

        // Directed vectors, back to back.
        for (int i = 0; i < 11; i++) begin
            if (ref_sum(tab_a[i], tab_b[i], tab_c[i]) !== tab_e[i])
                $display("note: table row %0d inconsistent", i);
            apply_vec($sformatf("directed_%0d+%0d+%0d", tab_a[i], tab_b[i], tab_c[i]),
                      tab_a[i], tab_b[i], tab_c[i]);
        end

        // Input changes between edges must not reach the outputs.
        apply_vec("glitch_base", 4'd6, 4'd5, 1'b0);
        held = ref_sum(4'd6, 4'd5, 1'b0);
        @(negedge clk);
        in1 = 4'd15;
        in2 = 4'd15;
        cin = 1'b1;
        #2;
        check_eq("glitch_no_effect", {cout, out}, held);
        in1 = 4'd1;
        in2 = 4'd1;
        cin = 1'b0;
        @(posedge clk);
        #1;
        check_eq("glitch_last_value_loaded", {cout, out}, 5'd2);

        // Random back-to-back traffic.
        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            apply_vec("random", ra, rb, rc);
        end

        // Exhaustive sweep with periodic async reset pulses.
        for (int k = 0; k < 512; k++) begin
            apply_vec($sformatf("sweep_%0d", k), 4'(k >> 5), 4'(k >> 1), 1'(k));
            if (k % 128 == 77) begin
                #1;
                rst_n = 1'b0;
                #1;
                check_eq($sformatf("sweep_reset_clear_%0d", k), {cout, out}, 5'd0);
                #1;
                rst_n = 1'b1;
                #1;
                check_eq($sformatf("sweep_reset_hold_%0d", k), {cout, out}, 5'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
